// File: rtl/uart_rx_pkg.sv
// Shared types and legal-range constants for the UART receive deserializer.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_STOP} rx_state_e;
`endif

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for the UART receiver: clear wins over enable, and the
// terminal count flags the last data bit of a frame.
module rx_bit_counter #(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART frame deserializer driven by bit-centre sample strobes, with a
// one-deep output register. Optional parity check: define UART_RX_PARITY_EN.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LSB_FIRST  = 1,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              serial_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);
    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_rx_deserializer: DATA_W out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $error("uart_rx_deserializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_rx_deserializer: PARITY_ODD must be 0 or 1");
    end

    rx_state_e         state_q, state_d;
    logic              armed_q;
    logic [DATA_W-1:0] shift_q;
    logic              stop_idx_q;
    logic              ferr_acc_q;
    logic              perr_acc;
    logic              cnt_tc;
    logic              start_det, shift_en, complete;
    logic              last_stop, frame_err_now;

    assign last_stop     = (STOP_BITS == 1) || stop_idx_q;
    assign frame_err_now = ferr_acc_q | ~serial_in;

    rx_bit_counter #(.DATA_W(DATA_W)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .clr (start_det),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sample_en) begin
            case (state_q)
                ST_IDLE:   if (!serial_in && armed_q) state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
                ST_DATA:   if (cnt_tc) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
`else
                ST_DATA:   if (cnt_tc) state_d = ST_STOP;
`endif
                ST_STOP:   if (last_stop) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start_det = 1'b0;
        shift_en  = 1'b0;
        complete  = 1'b0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: start_det = sample_en & ~serial_in & armed_q;
            ST_DATA: shift_en  = sample_en;
            ST_STOP: complete  = sample_en & last_stop;
            default: ;
        endcase
    end

    // Frame-local state; a framing error disarms so a break cannot retrigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q    <= 1'b0;
            shift_q    <= '0;
            stop_idx_q <= 1'b0;
            ferr_acc_q <= 1'b0;
        end else if (sample_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (serial_in) armed_q <= 1'b1;
                    stop_idx_q <= 1'b0;
                    ferr_acc_q <= 1'b0;
                end
                ST_DATA: begin
                    if (LSB_FIRST != 0) shift_q <= {serial_in, shift_q[DATA_W-1:1]};
                    else                shift_q <= {shift_q[DATA_W-2:0], serial_in};
                end
                ST_STOP: begin
                    if (!serial_in) ferr_acc_q <= 1'b1;
                    stop_idx_q <= ~stop_idx_q;
                    if (last_stop && frame_err_now) armed_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perr_q <= 1'b0;
        else if (sample_en && state_q == ST_PARITY)
            perr_q <= serial_in ^ (^shift_q) ^ PARITY_ODD[0];
    end
    assign perr_acc = perr_q;
`else
    assign perr_acc = 1'b0;
`endif

    // Output holding register: a completion against a stalled consumer is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    data_out  <= shift_q;
                    frame_err <= frame_err_now;
                    out_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= perr_acc;
`endif
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = perr_acc;
`endif

endmodule
